// File: rtl/data_cache_pkg.sv
// Shared types and address helpers for the data cache: state encoding,
// default geometry and address-field extraction.
package dcache_pkg;

  localparam int DC_NUM_LINES      = 16;
  localparam int DC_WORDS_PER_LINE = 4;
  localparam int OFF_W = $clog2(DC_WORDS_PER_LINE);
  localparam int IDX_W = $clog2(DC_NUM_LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    FILL      = 2'd3
  } state_e;

  // Fields are returned right-aligned in 32 bits; callers cast to their own width.
  function automatic logic [31:0] addr_offset(logic [31:0] addr, int off_w);
    return (addr >> 2) & ((32'd1 << off_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_index(logic [31:0] addr, int off_w, int idx_w);
    return (addr >> (2 + off_w)) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(logic [31:0] addr, int off_w, int idx_w);
    return addr >> (2 + off_w + idx_w);
  endfunction

endpackage

// File: rtl/data_cache_if.sv
// CPU request/response and data-memory signals of the data cache.
interface data_cache_if;

  // A request transfers on a posedge where req_valid && req_ready; the CPU holds
  // req_* stable until then. resp_valid is a one-cycle pulse per accepted request.
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_dout;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_dout,
    output req_ready, resp_valid, resp_rdata, mem_addr, mem_din, mem_read, mem_write
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_dout,
    input  req_ready, resp_valid, resp_rdata, mem_addr, mem_din, mem_read, mem_write
  );

endinterface

// File: rtl/data_cache_array.sv
// Tag/valid/dirty/data storage for the data cache: combinational read of one
// line, posedge write; only valid and dirty are cleared by reset.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int IDX_BITS = IDX_W,
  parameter int OFF_BITS = OFF_W,
  parameter int TAG_BITS = TAG_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] idx_i,
  input  logic [OFF_BITS-1:0] rd_off_i,
  output logic                rd_valid_o,
  output logic                rd_dirty_o,
  output logic [TAG_BITS-1:0] rd_tag_o,
  output logic [31:0]         rd_word_o,
  input  logic                word_we_i,
  input  logic [OFF_BITS-1:0] wr_off_i,
  input  logic [31:0]         wr_word_i,
  input  logic                meta_we_i,
  input  logic                meta_valid_i,
  input  logic                meta_dirty_i,
  input  logic [TAG_BITS-1:0] meta_tag_i
);

  localparam int LINES = 1 << IDX_BITS;
  localparam int WORDS = 1 << (IDX_BITS + OFF_BITS);

  logic [LINES-1:0]    valid_q;
  logic [LINES-1:0]    dirty_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [31:0]         data_q [WORDS];

  assign rd_valid_o = valid_q[idx_i];
  assign rd_dirty_o = dirty_q[idx_i];
  assign rd_tag_o   = tag_q[idx_i];
  assign rd_word_o  = data_q[{idx_i, rd_off_i}];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (meta_we_i) begin
      valid_q[idx_i] <= meta_valid_i;
      dirty_q[idx_i] <= meta_dirty_i;
    end
  end

  always_ff @(posedge clk) begin
    if (meta_we_i) tag_q[idx_i] <= meta_tag_i;
    if (word_we_i) data_q[{idx_i, wr_off_i}] <= wr_word_i;
  end

endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate data cache.
// Hit/miss statistics counters exist only when DCACHE_STATS_EN is defined.
module data_cache
  import dcache_pkg::*;
#(
  parameter int NUM_LINES      = DC_NUM_LINES,
  parameter int WORDS_PER_LINE = DC_WORDS_PER_LINE
) (
  input  logic        clk,
  input  logic        reset,
  data_cache_if.slave bus,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int OFF_BITS = $clog2(WORDS_PER_LINE);
  localparam int IDX_BITS = $clog2(NUM_LINES);
  localparam int TAG_BITS = 30 - OFF_BITS - IDX_BITS;
  localparam logic [OFF_BITS-1:0] LAST_WORD = OFF_BITS'(WORDS_PER_LINE - 1);

  state_e              state_q, state_d;
  logic [OFF_BITS-1:0] cnt_q, cnt_d;
  logic [31:0]         addr_q, addr_d, wdata_q, wdata_d;
  logic                write_q, write_d;
  logic                resp_valid_q, resp_valid_d;
  logic [31:0]         resp_rdata_q, resp_rdata_d;

  logic [OFF_BITS-1:0] req_off, rd_off, wr_off;
  logic [IDX_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0] req_tag, rd_tag;
  logic                rd_valid, rd_dirty, lookup_hit;
  logic [31:0]         rd_word, wr_word;
  logic                word_we, meta_we, meta_dirty;
  logic                req_ready, mem_read, mem_write;
  logic [31:0]         mem_addr, mem_din;

  assign req_off    = OFF_BITS'(addr_offset(addr_q, OFF_BITS));
  assign req_idx    = IDX_BITS'(addr_index(addr_q, OFF_BITS, IDX_BITS));
  assign req_tag    = TAG_BITS'(addr_tag(addr_q, OFF_BITS, IDX_BITS));
  assign lookup_hit = rd_valid && (rd_tag == req_tag);

  dcache_array #(
    .IDX_BITS(IDX_BITS),
    .OFF_BITS(OFF_BITS),
    .TAG_BITS(TAG_BITS)
  ) u_array (
    .clk         (clk),
    .reset       (reset),
    .idx_i       (req_idx),
    .rd_off_i    (rd_off),
    .rd_valid_o  (rd_valid),
    .rd_dirty_o  (rd_dirty),
    .rd_tag_o    (rd_tag),
    .rd_word_o   (rd_word),
    .word_we_i   (word_we),
    .wr_off_i    (wr_off),
    .wr_word_i   (wr_word),
    .meta_we_i   (meta_we),
    .meta_valid_i(1'b1),
    .meta_dirty_i(meta_dirty),
    .meta_tag_i  (req_tag)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    rd_off       = cnt_q;
    word_we      = 1'b0;
    wr_off       = cnt_q;
    wr_word      = bus.mem_dout;
    meta_we      = 1'b0;
    meta_dirty   = 1'b0;
    req_ready    = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = '0;
    mem_din      = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          write_d = bus.req_write;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        rd_off = req_off;
        if (lookup_hit) begin
          resp_valid_d = 1'b1;
          state_d      = IDLE;
          if (write_q) begin
            word_we      = 1'b1;
            wr_off       = req_off;
            wr_word      = wdata_q;
            meta_we      = 1'b1;
            meta_dirty   = 1'b1;
            resp_rdata_d = wdata_q;
          end else begin
            resp_rdata_d = rd_word;
          end
        end else begin
          cnt_d   = '0;
          state_d = (rd_valid && rd_dirty) ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        mem_write = 1'b1;
        mem_addr  = {rd_tag, req_idx, cnt_q, 2'b00};
        mem_din   = rd_word;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_WORD) state_d = FILL;
      end
      FILL: begin
        mem_read = 1'b1;
        mem_addr = {req_tag, req_idx, cnt_q, 2'b00};
        word_we  = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        // The last word also publishes tag/valid; the line stays clean.
        if (cnt_q == LAST_WORD) begin
          meta_we = 1'b1;
          state_d = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_din    = mem_din;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count_q, miss_count_q;
  logic        relookup_q;

  // The COMPARE that follows a fill always hits and is not a new lookup.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
      relookup_q   <= 1'b0;
    end else if (state_q == COMPARE) begin
      if (!lookup_hit)      miss_count_q <= miss_count_q + 32'd1;
      else if (!relookup_q) hit_count_q  <= hit_count_q + 32'd1;
      relookup_q <= 1'b0;
    end else if (state_q == FILL && cnt_q == LAST_WORD) begin
      relookup_q <= 1'b1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule
